// File: rtl/tl_host_arbiter.sv
// +----------------------------------------------------------------------------+
// | tl_host_arbiter: round-robin TL-UL host-to-device arbiter with source tag  |
// | routing and per-host outstanding limits.            Revision: 1.0          |
// +----------------------------------------------------------------------------+
`default_nettype none

package bus_params_pkg;
  parameter int BUS_AW  = 32;
  parameter int BUS_DW  = 32;
  parameter int BUS_SZW = 2;
  parameter int BUS_AIW = 8;
endpackage

module tl_host_arbiter #(
  parameter int NumHosts = 4,
  parameter int AW       = bus_params_pkg::BUS_AW,
  parameter int DW       = bus_params_pkg::BUS_DW,
  parameter int SZW      = bus_params_pkg::BUS_SZW,
  parameter int AIW      = bus_params_pkg::BUS_AIW,
  parameter int MaxOut   = 4,
  localparam int IdxW    = $clog2(NumHosts),
  localparam int DBW     = DW / 8,
  localparam int ApW     = 3 + AW + DW + DBW + SZW,
  localparam int DpW     = 3 + DW + SZW + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumHosts-1:0]     host_a_valid_i,
  output logic [NumHosts-1:0]     host_a_ready_o,
  input  logic [NumHosts*ApW-1:0] host_a_payload_i,
  input  logic [NumHosts*AIW-1:0] host_a_source_i,
  output logic                    dev_a_valid_o,
  input  logic                    dev_a_ready_i,
  output logic [ApW-1:0]          dev_a_payload_o,
  output logic [AIW-1:0]          dev_a_source_o,
  input  logic                    dev_d_valid_i,
  output logic                    dev_d_ready_o,
  input  logic [DpW-1:0]          dev_d_payload_i,
  input  logic [AIW-1:0]          dev_d_source_i,
  output logic [NumHosts-1:0]     host_d_valid_o,
  input  logic [NumHosts-1:0]     host_d_ready_i,
  output logic [DpW-1:0]          host_d_payload_o,
  output logic [AIW-1:0]          host_d_source_o,
  output logic                    err_o
);

  localparam int CntW   = $clog2(MaxOut + 1);
  localparam int SrcLoW = AIW - IdxW;

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic            lock_q, lock_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q [NumHosts];
  logic [CntW-1:0] cnt_d [NumHosts];

  logic [NumHosts-1:0] elig;
  logic [IdxW-1:0]     rr_grant;
  logic [IdxW:0]       idx_ext;
  logic [IdxW-1:0]     grant;
  logic                lock_valid;
  logic                violation;
  logic                a_acc;
  logic [AIW-1:0]      grant_src;
  logic                src_hi_bad;
  logic [IdxW-1:0]     d_idx;
  logic                d_in_range;
  logic                d_acc;

  // A channel: eligibility, round-robin scan from ptr, lock override.
  always_comb begin
    for (int k = 0; k < NumHosts; k++) begin
      elig[k] = host_a_valid_i[k] && (cnt_q[k] < CntW'(MaxOut));
    end

    // Scan downward so the smallest offset from ptr wins.
    rr_grant = ptr_q;
    idx_ext  = '0;
    for (int i = NumHosts - 1; i >= 0; i--) begin
      idx_ext = {1'b0, ptr_q} + (IdxW+1)'(i);
      if (idx_ext >= (IdxW+1)'(NumHosts)) begin
        idx_ext = idx_ext - (IdxW+1)'(NumHosts);
      end
      if (elig[idx_ext[IdxW-1:0]]) begin
        rr_grant = idx_ext[IdxW-1:0];
      end
    end

    lock_valid = 1'b0;
    for (int k = 0; k < NumHosts; k++) begin
      if (lock_idx_q == IdxW'(k)) lock_valid = host_a_valid_i[k];
    end
    violation     = lock_q && !lock_valid;
    grant         = lock_q ? lock_idx_q : rr_grant;
    dev_a_valid_o = lock_q ? !violation : |elig;
    a_acc         = dev_a_valid_o && dev_a_ready_i;

    host_a_ready_o  = '0;
    dev_a_payload_o = '0;
    grant_src       = '0;
    for (int k = 0; k < NumHosts; k++) begin
      if (grant == IdxW'(k)) begin
        host_a_ready_o[k] = dev_a_valid_o && dev_a_ready_i;
        dev_a_payload_o   = host_a_payload_i[k*ApW +: ApW];
        grant_src         = host_a_source_i[k*AIW +: AIW];
      end
    end
    src_hi_bad     = |grant_src[AIW-1 -: IdxW];
    dev_a_source_o = {grant, grant_src[SrcLoW-1:0]};
  end

  // D channel: route by the tag in the upper source bits; unknown tags are sunk.
  always_comb begin
    d_idx          = dev_d_source_i[AIW-1 -: IdxW];
    d_in_range     = {1'b0, d_idx} < (IdxW+1)'(NumHosts);
    host_d_valid_o = '0;
    dev_d_ready_o  = 1'b1;
    if (d_in_range) begin
      for (int k = 0; k < NumHosts; k++) begin
        if (d_idx == IdxW'(k)) begin
          host_d_valid_o[k] = dev_d_valid_i;
          dev_d_ready_o     = host_d_ready_i[k];
        end
      end
    end
    d_acc            = dev_d_valid_i && dev_d_ready_o && d_in_range;
    host_d_payload_o = dev_d_payload_i;
    host_d_source_o  = {{IdxW{1'b0}}, dev_d_source_i[SrcLoW-1:0]};
  end

  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    err_d      = err_q;

    if (violation) begin
      lock_d = 1'b0;
      err_d  = 1'b1;
    end else if (a_acc) begin
      lock_d = 1'b0;
      ptr_d  = (grant == IdxW'(NumHosts - 1)) ? '0 : grant + 1'b1;
      if (src_hi_bad) err_d = 1'b1;
    end else if (dev_a_valid_o) begin
      lock_d     = 1'b1;
      lock_idx_d = grant;
    end

    if (dev_d_valid_i && !d_in_range) err_d = 1'b1;

    // A matching accept and response in the same cycle cancel out.
    for (int k = 0; k < NumHosts; k++) begin
      cnt_d[k] = cnt_q[k];
      if (a_acc && (grant == IdxW'(k)) && !(d_acc && (d_idx == IdxW'(k)))) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end else if (d_acc && (d_idx == IdxW'(k)) && !(a_acc && (grant == IdxW'(k)))) begin
        if (cnt_q[k] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
      for (int k = 0; k < NumHosts; k++) cnt_q[k] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
      for (int k = 0; k < NumHosts; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign err_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_tl_host_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_tl_host_arbiter: scoreboard bench for tl_host_arbiter (4 and 3 hosts).  |
// |                                                      Revision: 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_tl_host_arbiter;

  localparam int NH  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SZW = 2;
  localparam int AIW = 8;
  localparam int MO  = 4;
  localparam int ApW = 3 + AW + DW + DW/8 + SZW;
  localparam int DpW = 3 + DW + SZW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NH-1:0]     host_a_valid, host_a_ready;
  logic [NH*ApW-1:0] host_a_payload;
  logic [NH*AIW-1:0] host_a_source;
  logic              dev_a_valid, dev_a_ready;
  logic [ApW-1:0]    dev_a_payload;
  logic [AIW-1:0]    dev_a_source;
  logic              dev_d_valid, dev_d_ready;
  logic [DpW-1:0]    dev_d_payload;
  logic [AIW-1:0]    dev_d_source;
  logic [NH-1:0]     host_d_valid, host_d_ready;
  logic [DpW-1:0]    host_d_payload;
  logic [AIW-1:0]    host_d_source;
  logic              err;

  tl_host_arbiter #(.NumHosts(NH), .AW(AW), .DW(DW), .SZW(SZW), .AIW(AIW), .MaxOut(MO)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .host_a_valid_i(host_a_valid), .host_a_ready_o(host_a_ready),
    .host_a_payload_i(host_a_payload), .host_a_source_i(host_a_source),
    .dev_a_valid_o(dev_a_valid), .dev_a_ready_i(dev_a_ready),
    .dev_a_payload_o(dev_a_payload), .dev_a_source_o(dev_a_source),
    .dev_d_valid_i(dev_d_valid), .dev_d_ready_o(dev_d_ready),
    .dev_d_payload_i(dev_d_payload), .dev_d_source_i(dev_d_source),
    .host_d_valid_o(host_d_valid), .host_d_ready_i(host_d_ready),
    .host_d_payload_o(host_d_payload), .host_d_source_o(host_d_source),
    .err_o(err)
  );

  // Three-host instance: exercises the unused d_idx = 3 tag.
  logic [2:0]       h3_a_valid, h3_a_ready, h3_d_valid, h3_d_ready;
  logic [3*ApW-1:0] h3_a_payload;
  logic [3*AIW-1:0] h3_a_source;
  logic             d3_a_valid, d3_d_valid, d3_d_ready, err3;
  logic [ApW-1:0]   d3_a_payload;
  logic [AIW-1:0]   d3_a_source, d3_d_source, h3_d_source;
  logic [DpW-1:0]   d3_d_payload, h3_d_payload;

  tl_host_arbiter #(.NumHosts(3), .AW(AW), .DW(DW), .SZW(SZW), .AIW(AIW), .MaxOut(MO)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .host_a_valid_i(h3_a_valid), .host_a_ready_o(h3_a_ready),
    .host_a_payload_i(h3_a_payload), .host_a_source_i(h3_a_source),
    .dev_a_valid_o(d3_a_valid), .dev_a_ready_i(1'b1),
    .dev_a_payload_o(d3_a_payload), .dev_a_source_o(d3_a_source),
    .dev_d_valid_i(d3_d_valid), .dev_d_ready_o(d3_d_ready),
    .dev_d_payload_i(d3_d_payload), .dev_d_source_i(d3_d_source),
    .host_d_valid_o(h3_d_valid), .host_d_ready_i(h3_d_ready),
    .host_d_payload_o(h3_d_payload), .host_d_source_o(h3_d_source),
    .err_o(err3)
  );

  typedef struct {
    logic [AIW-1:0] src;
    logic [ApW-1:0] pay;
    logic [NH-1:0]  rdy;
  } a_exp_t;

  typedef struct {
    int             host;
    logic [DpW-1:0] pay;
    logic [AIW-1:0] src;
  } d_exp_t;

  a_exp_t a_q[$];
  d_exp_t d_q[$];

  int n_chk = 0;
  int n_err = 0;
  int acc_cnt [NH];
  int tgt     [NH];
  logic [1:0] src_hi [NH];

  function automatic logic [ApW-1:0] mk_pay(int k, int n);
    logic [31:0] addr, data;
    addr = 32'h1000_0000 + 32'(k*256 + n);
    data = 32'hA5A5_0000 + 32'(k*16 + n);
    return {3'(n % 5), addr, data, 4'hF, 2'd2};
  endfunction

  function automatic logic [5:0] mk_lo(int k, int n);
    return 6'(k*8 + n);
  endfunction

  task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Host k presents request number acc_cnt[k] until it has reached tgt[k] accepts.
  task automatic drive();
    for (int k = 0; k < NH; k++) begin
      host_a_valid[k]                 = acc_cnt[k] < tgt[k];
      host_a_payload[k*ApW +: ApW]    = mk_pay(k, acc_cnt[k]);
      host_a_source[k*AIW +: AIW]     = {src_hi[k], mk_lo(k, acc_cnt[k])};
    end
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    #1;
  endtask

  task automatic exp_a(int k, int n);
    a_exp_t e;
    e.src = {2'(k), mk_lo(k, n)};
    e.pay = mk_pay(k, n);
    e.rdy = NH'(1 << k);
    a_q.push_back(e);
  endtask

  task automatic wait_a(string name, int budget);
    int b;
    b = 0;
    while (a_q.size() != 0 && b < budget) begin
      step();
      b++;
    end
    chk(name, 128'(a_q.size()), 128'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dev_d_valid = 1'b0;
    d3_d_valid  = 1'b0;
    for (int k = 0; k < NH; k++) tgt[k] = acc_cnt[k];
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic monitor();
    a_exp_t ea;
    d_exp_t ed;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < NH; k++) begin
          if (host_a_valid[k] && host_a_ready[k]) acc_cnt[k]++;
        end
        if (dev_a_valid && dev_a_ready) begin
          if (a_q.size() == 0) begin
            chk("a_unexpected_accept", 128'(dev_a_source), 128'hFFFF);
          end else begin
            ea = a_q.pop_front();
            chk("a_accept", {dev_a_source, dev_a_payload, host_a_ready},
                {ea.src, ea.pay, ea.rdy});
          end
        end
        for (int k = 0; k < NH; k++) begin
          if (host_d_valid[k] && host_d_ready[k]) begin
            if (d_q.size() == 0) begin
              chk("d_unexpected_accept", 128'(k), 128'hFFFF);
            end else begin
              ed = d_q.pop_front();
              chk("d_accept", {32'(k), host_d_payload, host_d_source},
                  {32'(ed.host), ed.pay, ed.src});
            end
          end
        end
      end
    end
  endtask

  logic [DpW-1:0] dpay;
  d_exp_t de;

  initial begin
    for (int k = 0; k < NH; k++) begin
      acc_cnt[k] = 0;
      tgt[k]     = 0;
      src_hi[k]  = 2'b00;
    end
    dev_a_ready   = 1'b0;
    dev_d_valid   = 1'b0;
    dev_d_payload = '0;
    dev_d_source  = '0;
    host_d_ready  = '0;
    h3_a_valid    = '0;
    h3_a_payload  = '0;
    h3_a_source   = '0;
    h3_d_ready    = '0;
    d3_d_valid    = 1'b0;
    d3_d_payload  = '0;
    d3_d_source   = '0;
    drive();
    fork
      monitor();
    join_none

    // Reset state, with device ready high so ready gating is visible.
    do_reset();
    dev_a_ready = 1'b1;
    settle();
    chk("reset_dev_a_valid", 128'(dev_a_valid), 128'd0);
    chk("reset_host_a_ready", 128'(host_a_ready), 128'd0);
    chk("reset_err", 128'(err), 128'd0);
    chk("reset_err3", 128'(err3), 128'd0);

    // Round robin: 0,1,2,3,0.
    exp_a(0, acc_cnt[0]); exp_a(1, acc_cnt[1]); exp_a(2, acc_cnt[2]);
    exp_a(3, acc_cnt[3]); exp_a(0, acc_cnt[0] + 1);
    tgt[0] += 2; tgt[1] += 1; tgt[2] += 1; tgt[3] += 1;
    settle();
    wait_a("rr_drained", 20);

    // Stall lock: grant holds on host 1 even after host 0 (ptr) starts requesting.
    do_reset();
    dev_a_ready = 1'b0;
    exp_a(1, acc_cnt[1]); exp_a(2, acc_cnt[2]); exp_a(0, acc_cnt[0]);
    tgt[1] += 1; tgt[2] += 1;
    settle();
    for (int c = 0; c < 3; c++) begin
      chk("stall_valid", 128'(dev_a_valid), 128'd1);
      chk("stall_src_payload", {dev_a_source, dev_a_payload},
          {2'd1, mk_lo(1, acc_cnt[1]), mk_pay(1, acc_cnt[1])});
      chk("stall_host_ready", 128'(host_a_ready), 128'd0);
      if (c == 0) tgt[0] += 1;
      step();
    end
    dev_a_ready = 1'b1;
    settle();
    wait_a("stall_drained", 20);

    // Outstanding limit: host 0 blocked at 4, host 3 served, D reopens host 0.
    do_reset();
    dev_a_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_a(0, acc_cnt[0] + i);
    tgt[0] += 5;
    settle();
    wait_a("limit_first4", 20);
    step();
    chk("limit_blocked_valid", 128'(dev_a_valid), 128'd0);
    chk("limit_blocked_ready", 128'(host_a_ready), 128'd0);
    exp_a(3, acc_cnt[3]);
    tgt[3] += 1;
    settle();
    wait_a("limit_host3", 10);
    dpay = {3'd1, 32'hCAFE_0003, 2'd2, 1'b0};
    de.host = 0; de.pay = dpay; de.src = 8'h03;
    d_q.push_back(de);
    dev_d_payload = dpay;
    dev_d_source  = {2'd0, 6'h03};
    host_d_ready  = 4'b0001;
    dev_d_valid   = 1'b1;
    settle();
    chk("limit_blocked_during_d", 128'(dev_a_valid), 128'd0);
    exp_a(0, acc_cnt[0]);
    step();
    dev_d_valid = 1'b0;
    settle();
    chk("limit_reenter", {dev_a_valid, dev_a_source[7:6]}, {1'b1, 2'd0});
    wait_a("limit_reenter_drained", 5);
    chk("limit_no_err", 128'(err), 128'd0);

    // D routing to host 2, then underflow (cnt[2] == 0).
    dpay = {3'd1, 32'hCAFE_0015, 2'd2, 1'b0};
    dev_d_payload = dpay;
    dev_d_source  = {2'd2, 6'h15};
    host_d_ready  = 4'b1011;
    dev_d_valid   = 1'b1;
    settle();
    chk("d_route_valid", 128'(host_d_valid), 128'b0100);
    chk("d_route_ready_low", 128'(dev_d_ready), 128'd0);
    chk("d_route_src", 128'(host_d_source), 128'h15);
    chk("d_route_payload", 128'(host_d_payload), 128'(dpay));
    de.host = 2; de.pay = dpay; de.src = 8'h15;
    d_q.push_back(de);
    host_d_ready = 4'b1111;
    settle();
    chk("d_route_ready_high", 128'(dev_d_ready), 128'd1);
    step();
    dev_d_valid = 1'b0;
    settle();
    chk("d_underflow_err", 128'(err), 128'd1);
    // A held-at-zero counter leaves host 2 eligible.
    exp_a(2, acc_cnt[2]);
    tgt[2] += 1;
    settle();
    wait_a("underflow_cnt_held", 10);
    repeat (3) step();
    chk("err_sticky", 128'(err), 128'd1);

    // Source upper bits set: forwarded with tag overwritten, error raised.
    do_reset();
    chk("reset_clears_err", 128'(err), 128'd0);
    src_hi[1] = 2'b11;
    exp_a(1, acc_cnt[1]);
    tgt[1] += 1;
    settle();
    wait_a("src_hi_forwarded", 10);
    chk("src_hi_err", 128'(err), 128'd1);
    src_hi[1] = 2'b00;

    // Valid drop while locked.
    do_reset();
    dev_a_ready = 1'b0;
    tgt[2] += 1;
    settle();
    step();
    tgt[2] = acc_cnt[2];
    tgt[1] += 1;
    settle();
    chk("drop_no_forward", 128'(dev_a_valid), 128'd0);
    chk("drop_err_not_yet", 128'(err), 128'd0);
    step();
    chk("drop_err", 128'(err), 128'd1);
    chk("drop_unlocked_next", {dev_a_valid, dev_a_source[7:6]}, {1'b1, 2'd1});
    exp_a(1, acc_cnt[1]);
    dev_a_ready = 1'b1;
    settle();
    wait_a("drop_drained", 10);

    // Three hosts: tag 3 is sunk and flagged.
    d3_d_payload = {3'd1, 32'h0000_0001, 2'd0, 1'b0};
    d3_d_source  = {2'd3, 6'h01};
    h3_d_ready   = 3'b000;
    d3_d_valid   = 1'b1;
    settle();
    chk("nh3_bad_idx_ready", 128'(d3_d_ready), 128'd1);
    chk("nh3_bad_idx_valid", 128'(h3_d_valid), 128'd0);
    step();
    d3_d_valid = 1'b0;
    settle();
    chk("nh3_bad_idx_err", 128'(err3), 128'd1);

    chk("a_queue_empty", 128'(a_q.size()), 128'd0);
    chk("d_queue_empty", 128'(d_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
